sys_cmd_ctrl: RTL

Command sequencer between the UART receive/transmit path and the register-file/ALU datapath, in the REF_CLK domain of the system top. Each command is decoded from a stream of received bytes. The block sequences register-file writes and reads and ALU operations, then returns read data or the 16-bit ALU result to the UART transmitter as byte frames. The supported opcodes are 0xAA write, 0xBB read, 0xCC ALU-with-operands and 0xDD ALU-no-operand.

---
 rtl/sys_cmd_ctrl_pkg.sv | 27 ++
 rtl/sys_cmd_ctrl_if.sv | 36 +++
 rtl/sys_cmd_tx_seq.sv | 78 +++++++
 rtl/sys_cmd_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared opcodes, operand addresses and FSM state encoding for the command sequencer.
package sys_cmd_ctrl_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam logic [3:0] OPER_A_ADDR = 4'd0;
  localparam logic [3:0] OPER_B_ADDR = 4'd1;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WR_ADDR    = 4'd1,
    WR_DATA    = 4'd2,
    RD_ADDR    = 4'd3,
    RD_WAIT    = 4'd4,
    ALU_A      = 4'd5,
    ALU_B      = 4'd6,
    ALU_FUN    = 4'd7,
    ALU_WAIT   = 4'd8,
    TX_LOAD    = 4'd9,
    TX_WAIT_HI = 4'd10,
    TX_WAIT_LO = 4'd11
  } state_t;

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between the command sequencer (master) and the UART / register-file / ALU side (slave).
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RF_RD_DATA;
  logic                    RF_RD_VLD;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    TX_BUSY;
  logic [ADDR_WIDTH-1:0]   RF_ADDR;
  logic                    RF_WR_EN;
  logic                    RF_RD_EN;
  logic [DATA_WIDTH-1:0]   RF_WR_DATA;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_GATE_EN;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/sys_cmd_tx_seq.sv
// Response transmitter: buffers a 1- or 2-byte response and paces it LSB first against TX_BUSY.
module sys_cmd_tx_seq
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    two_bytes,
  input  logic [2*DATA_WIDTH-1:0] resp,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_vld,
  output logic                    done
);

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] resp_buf;
  logic                    more;

  // Byte handshake: load when idle line, then see busy rise and fall before the next byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      resp_buf  <= '0;
      more      <= 1'b0;
      tx_p_data <= '0;
      tx_d_vld  <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_d_vld <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            resp_buf <= resp;
            more     <= two_bytes;
            // Launch immediately when the line is free to keep the one-cycle response latency.
            if (!tx_busy) begin
              tx_p_data <= resp[DATA_WIDTH-1:0];
              tx_d_vld  <= 1'b1;
              state     <= TX_WAIT_HI;
            end else begin
              state <= TX_LOAD;
            end
          end
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_p_data <= resp_buf[DATA_WIDTH-1:0];
            tx_d_vld  <= 1'b1;
            state     <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (tx_busy) begin
            state <= TX_WAIT_LO;
          end
        end
        TX_WAIT_LO: begin
          if (!tx_busy) begin
            if (more) begin
              resp_buf <= {{DATA_WIDTH{1'b0}}, resp_buf[2*DATA_WIDTH-1:DATA_WIDTH]};
              more     <= 1'b0;
              state    <= TX_LOAD;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes UART byte commands into register-file / ALU operations and responses.
// Optional inter-byte timeout is enabled with `define SYS_CMD_CTRL_TIMEOUT_EN.
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
`ifdef SYS_CMD_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  sys_cmd_ctrl_if.master       bus
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic                    alu_en;
  logic [FUN_WIDTH-1:0]    alu_fun;
  logic                    clk_gate_en;
  logic                    cmd_err;
  logic                    tx_start;
  logic                    tx_two;
  logic [2*DATA_WIDTH-1:0] tx_resp;
  logic                    tx_done;
  logic [DATA_WIDTH-1:0]   tx_p_data;
  logic                    tx_d_vld;

  // Response capture; a valid pulse coinciding with its own request strobe is ignored.
  always_comb begin
    tx_start = 1'b0;
    tx_two   = 1'b0;
    tx_resp  = '0;
    if (state == RD_WAIT && bus.RF_RD_VLD && !rf_rd_en) begin
      tx_start = 1'b1;
      tx_resp  = {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
    end else if (state == ALU_WAIT && bus.ALU_OUT_VLD && !alu_en) begin
      tx_start = 1'b1;
      tx_two   = 1'b1;
      tx_resp  = bus.ALU_OUT;
    end else begin
      tx_start = 1'b0;
    end
  end

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_cmd;
  logic             tmo_hit;

  assign in_cmd  = (state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN});
  assign tmo_hit = in_cmd && !bus.RX_D_VLD && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter, cleared by every received byte and outside byte-collecting states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt <= '0;
    end else if (in_cmd && !bus.RX_D_VLD) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

  // Main command FSM with registered strobes and operand/address holding registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      rf_addr     <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.RX_D_VLD) begin
            case (bus.RX_P_DATA)
              OP_WR:      state <= WR_ADDR;
              OP_RD:      state <= RD_ADDR;
              OP_ALU_OP: begin
                state       <= ALU_A;
                clk_gate_en <= 1'b1;
              end
              OP_ALU_NOP: begin
                state       <= ALU_FUN;
                clk_gate_en <= 1'b1;
              end
              default:    cmd_err <= 1'b1;
            endcase
          end
        end
        WR_ADDR: if (bus.RX_D_VLD) begin
          rf_addr <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state   <= WR_DATA;
        end
        WR_DATA: if (bus.RX_D_VLD) begin
          rf_wr_data <= bus.RX_P_DATA;
          rf_wr_en   <= 1'b1;
          state      <= IDLE;
        end
        RD_ADDR: if (bus.RX_D_VLD) begin
          rf_addr  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en <= 1'b1;
          state    <= RD_WAIT;
        end
        RD_WAIT: if (tx_start) state <= TX_LOAD;
        ALU_A: if (bus.RX_D_VLD) begin
          rf_addr    <= ADDR_WIDTH'(OPER_A_ADDR);
          rf_wr_data <= bus.RX_P_DATA;
          rf_wr_en   <= 1'b1;
          state      <= ALU_B;
        end
        ALU_B: if (bus.RX_D_VLD) begin
          rf_addr    <= ADDR_WIDTH'(OPER_B_ADDR);
          rf_wr_data <= bus.RX_P_DATA;
          rf_wr_en   <= 1'b1;
          state      <= ALU_FUN;
        end
        ALU_FUN: if (bus.RX_D_VLD) begin
          alu_fun <= bus.RX_P_DATA[FUN_WIDTH-1:0];
          alu_en  <= 1'b1;
          state   <= ALU_WAIT;
        end
        ALU_WAIT: if (tx_start) begin
          clk_gate_en <= 1'b0;
          state       <= TX_LOAD;
        end
        // The byte pacing itself lives in the tx sequencer; here we only wait for it to finish.
        TX_LOAD: if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef SYS_CMD_CTRL_TIMEOUT_EN
      if (tmo_hit) begin
        cmd_err     <= 1'b1;
        clk_gate_en <= 1'b0;
        state       <= IDLE;
      end
`endif
    end
  end

  sys_cmd_tx_seq #(.DATA_WIDTH(DATA_WIDTH)) u_tx_seq (
    .clk       (CLK),
    .rst       (RST),
    .start     (tx_start),
    .two_bytes (tx_two),
    .resp      (tx_resp),
    .tx_busy   (bus.TX_BUSY),
    .tx_p_data (tx_p_data),
    .tx_d_vld  (tx_d_vld),
    .done      (tx_done)
  );

  assign bus.RF_ADDR     = rf_addr;
  assign bus.RF_WR_EN    = rf_wr_en;
  assign bus.RF_RD_EN    = rf_rd_en;
  assign bus.RF_WR_DATA  = rf_wr_data;
  assign bus.ALU_EN      = alu_en;
  assign bus.ALU_FUN     = alu_fun;
  assign bus.CLK_GATE_EN = clk_gate_en;
  assign bus.CMD_ERR     = cmd_err;
  assign bus.TX_P_DATA   = tx_p_data;
  assign bus.TX_D_VLD    = tx_d_vld;

endmodule
